// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the iterative integer divider.
// Iteration count matches the operand width; one quotient bit per iteration.
package mips_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;

  // Quotient returned for a zero divisor (all ones, DIV and DIVU alike).
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare
// against the divisor and conditionally subtract. Purely combinational.
module div_step
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic             w_ge;

  assign w_shift = {i_rem, i_bit};
  assign w_ge    = (w_shift >= {2'b00, i_divisor});
  assign o_qbit  = w_ge;
  assign o_rem   = w_ge ? (w_shift[WIDTH:0] - {1'b0, i_divisor}) : w_shift[WIDTH:0];

endmodule

// File: rtl/divide_unit.sv
// Multi-cycle DIV/DIVU unit: magnitudes are divided unsigned, signs applied in FIXUP.
// Start-to-done latency WIDTH+2; start is ignored while busy, flush aborts without done.
module divide_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem, w_rem_nxt;
  logic             w_qbit;
  // r_dvd shifts dividend bits out of the top and quotient bits in at the bottom
  logic [WIDTH-1:0] r_dvd, r_dsr, r_raw;
  logic             r_q_neg, r_r_neg, r_dz;
  logic             w_accept, w_step, w_fix;
  logic [WIDTH-1:0] w_dvd_abs, w_dsr_abs;

  logic             r_busy, r_done, r_dz_out;
  logic [WIDTH-1:0] r_quo, r_rmd;

  assign w_dvd_abs = (is_signed && dividend[WIDTH-1]) ? ({WIDTH{1'b0}} - dividend) : dividend;
  assign w_dsr_abs = (is_signed && divisor[WIDTH-1])  ? ({WIDTH{1'b0}} - divisor)  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[WIDTH-1]),
    .i_divisor (r_dsr),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_fix    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = CALC;
        end else begin
          w_next   = IDLE;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == '0) w_next = FIXUP;
      end
      FIXUP: begin
        w_fix  = 1'b1;
        w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
    // A pipeline kill overrides everything, including a same-cycle start.
    if (flush) begin
      w_next   = IDLE;
      w_accept = 1'b0;
      w_step   = 1'b0;
      w_fix    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_raw   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= CW'(WIDTH-1);
      r_rem   <= '0;
      r_dvd   <= w_dvd_abs;
      r_dsr   <= w_dsr_abs;
      r_raw   <= dividend;
      r_q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_r_neg <= is_signed & dividend[WIDTH-1];
      r_dz    <= (divisor == '0);
    end else if (w_step) begin
      r_cnt   <= r_cnt - CW'(1);
      r_rem   <= w_rem_nxt;
      r_dvd   <= {r_dvd[WIDTH-2:0], w_qbit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quo    <= '0;
      r_rmd    <= '0;
      r_dz_out <= 1'b0;
    end else begin
      r_busy <= (w_next == CALC) || (w_next == FIXUP);
      r_done <= (w_next == DONE);
      if (w_fix) begin
        r_dz_out <= r_dz;
        if (r_dz) begin
          r_quo <= DIV0_QUOTIENT[WIDTH-1:0];
          r_rmd <= r_raw;
        end else begin
          r_quo <= r_q_neg ? ({WIDTH{1'b0}} - r_dvd) : r_dvd;
          r_rmd <= r_r_neg ? ({WIDTH{1'b0}} - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quo;
  assign remainder   = r_rmd;
  assign div_by_zero = r_dz_out;

endmodule

// File: tb/tb_divide_unit.sv
// Directed bench for divide_unit: latency, signed/unsigned results, zero divisor,
// ignored/back-to-back starts, flush and asynchronous reset.
module tb_divide_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  divide_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Counts cycles after the accepting edge (first cycle = 1) until done is seen.
  task automatic wait_done(input int poke, output int cyc, output int bad);
    cyc = 1;
    bad = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) bad++;
      if (cyc == poke) begin
        dividend  = 32'd9;
        divisor   = 32'd3;
        is_signed = 1'b0;
        start     = 1'b1;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    if (done === 1'b1 && busy === 1'b1) bad++;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input int poke,
                     input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int cyc, bad;
    launch(a, b, s);
    wait_done(poke, cyc, bad);
    chk({tag, "_latency"}, cyc, 32'd34);
    chk({tag, "_busy_profile"}, bad, 32'd0);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_div_by_zero"}, {31'b0, div_by_zero}, {31'b0, edz});
  endtask

  initial begin
    int ndone;

    tick();
    tick();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    run("divu_100_7", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0);
    tick();
    chk("done_pulse_width", {31'b0, done}, 32'd0);
    chk("quotient_held", quotient, 32'd14);

    run("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    tick();
    run("divu_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 32'h7FFF_FFFC, 32'd1, 1'b0);
    tick();
    run("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0, 1'b0);
    tick();
    run("divu_5_0", 32'd5, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    tick();
    run("div_m7_0", 32'hFFFF_FFF9, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    tick();

    // start pulsed at cycle 10 while busy must be ignored
    run("ignored_start", 32'd100, 32'd7, 1'b0, 10, 32'd14, 32'd2, 1'b0);
    // launched from the DONE cycle, no bubble
    run("back_to_back", 32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0, 1'b0);
    tick();

    launch(32'd100, 32'd7, 1'b0);
    repeat (14) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    ndone = 0;
    repeat (40) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("flush_no_done", ndone, 32'd0);
    chk("flush_quotient_kept", quotient, 32'd3);
    chk("flush_remainder_kept", remainder, 32'd0);

    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    flush     = 1'b1;
    tick();
    start     = 1'b0;
    flush     = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    ndone = 0;
    repeat (36) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("flush_start_no_done", ndone, 32'd0);

    launch(32'd100, 32'd7, 1'b0);
    repeat (19) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midcalc_rst_busy", {31'b0, busy}, 32'd0);
    chk("midcalc_rst_done", {31'b0, done}, 32'd0);
    chk("midcalc_rst_quotient", quotient, 32'd0);
    chk("midcalc_rst_remainder", remainder, 32'd0);
    chk("midcalc_rst_dbz", {31'b0, div_by_zero}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run("after_reset", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
